bin2bcd_param: RTL

//   Parametrised sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.

---
 rtl/bin2bcd_param.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bin2bcd_param.sv
// ---------------------------------------------------------------------------
// bin2bcd_param
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
//   one operand bit per clock. Adds a start/busy/done handshake, optional
//   two's-complement operand, an overflow flag for undersized DIGITS and a
//   leading-zero digit mask for decimal displays.
//
// Parameters
//   WIDTH   binary operand width (>= 2)
//   DIGITS  number of BCD digits produced (>= 1)
//   SIGNED  1: operand is two's complement; magnitude converted, sign on neg
//
// Ports
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   conversion request, sampled only while idle
//   bin       in   operand, sampled on the edge that accepts start
//   busy      out  conversion in progress (WIDTH cycles)
//   done      out  one-cycle pulse; bcd/neg/overflow/digit_en just updated
//   bcd       out  result, digit i at [4i+3:4i], digit 0 least significant
//   neg       out  operand was negative (SIGNED=1 only)
//   overflow  out  magnitude >= 10**DIGITS; bcd holds magnitude mod 10**DIGITS
//   digit_en  out  bit i set when digit i or any higher digit is nonzero;
//                  bit 0 always set
// ---------------------------------------------------------------------------
module bin2bcd_param #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg,
  output logic                overflow,
  output logic [DIGITS-1:0]   digit_en
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sign_q, sign_d;
  logic               ovf_acc_q, ovf_acc_d;

  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic [DIGITS-1:0]  digit_en_q, digit_en_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               carry_out;
  logic               last_bit;
  logic               in_neg;

  // Digit i is enabled when any digit at or above i is nonzero.
  function automatic logic [DIGITS-1:0] lead_mask(input logic [BCD_W-1:0] v);
    logic seen;
    seen      = 1'b0;
    lead_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen         = seen | (|v[4*i +: 4]);
      lead_mask[i] = seen;
    end
    lead_mask[0] = 1'b1;
  endfunction

  // Add-3 correction on every digit in parallel, then shift one operand bit
  // in from the top of mag. The bit falling off the top digit means the
  // value no longer fits in DIGITS digits.
  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    shifted   = {adj[BCD_W-2:0], mag_q[WIDTH-1]};
    carry_out = adj[BCD_W-1];
    last_bit  = (count_q == CNT_W'(WIDTH - 1));
    in_neg    = SIGNED && bin[WIDTH-1];
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    work_d     = work_q;
    count_d    = count_q;
    sign_d     = sign_q;
    ovf_acc_d  = ovf_acc_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    digit_en_d = digit_en_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Negating the most negative value wraps to 2**(WIDTH-1), which is
          // exactly the correct unsigned magnitude.
          mag_d     = in_neg ? (~bin + WIDTH'(1)) : bin;
          sign_d    = in_neg;
          work_d    = '0;
          ovf_acc_d = 1'b0;
          count_d   = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        work_d    = shifted;
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | carry_out;
        count_d   = count_q + CNT_W'(1);
        if (last_bit) begin
          bcd_d      = shifted;
          neg_d      = sign_q;
          ovf_d      = ovf_acc_q | carry_out;
          digit_en_d = lead_mask(shifted);
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      work_q     <= '0;
      count_q    <= '0;
      sign_q     <= 1'b0;
      ovf_acc_q  <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      digit_en_q <= DIGITS'(1);
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      work_q     <= work_d;
      count_q    <= count_d;
      sign_q     <= sign_d;
      ovf_acc_q  <= ovf_acc_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      digit_en_q <= digit_en_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign neg      = neg_q;
  assign overflow = ovf_q;
  assign digit_en = digit_en_q;

endmodule
